alu3_serial_unit: RTL and testbench

- Sequential responder for the 3-bit ALU opcode set; the execution end that a stimulus driver talks to.
- Accepts one request (opcode, two operands, carry-in) over a valid/ready handshake.
- Computes the result bit-serially, LSB first, one bit per clock, using a single 1-bit gate/full-adder slice.
- Returns the result over a second valid/ready handshake.
- Sits between a request source (bench or sequencer) and a result consumer.

---
 rtl/alu3_serial_unit_if.sv | 26 ++
 rtl/alu3_serial_unit.sv | 115 +++++++++++
 tb/tb_alu3_serial_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu3_serial_unit_if.sv
// Request/response handshake bundle for the bit-serial 3-bit-opcode ALU.
// The master drives requests and consumes results. The slave is the ALU.
interface alu3_serial_unit_if #(
   parameter int unsigned WIDTH = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] result;
   logic             cout;

   modport master (
      output req_valid, op, a, b, cin, rsp_ready,
      input  req_ready, rsp_valid, result, cout
   );

   modport slave (
      input  req_valid, op, a, b, cin, rsp_ready,
      output req_ready, rsp_valid, result, cout
   );
endinterface

// File: rtl/alu3_serial_unit.sv
// Bit-serial ALU responder: one request in, WIDTH clocks through a 1-bit slice, one response out.
// Operands shift right so the slice always reads bit 0, and result bits enter from the MSB side.
module alu3_serial_unit #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CW    = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu3_serial_unit_if.slave    bus,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] s_ins;
   logic             carry_r;
   logic             cout_r;
   logic             bit_s;
   logic             carry_nxt;
   logic             is_add;
   logic             last_bit;

   assign is_add   = op_r[2] & op_r[1];
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Single 1-bit slice. Carry only moves for the two add opcodes.
   always_comb begin
      bit_s     = 1'b0;
      carry_nxt = carry_r;
      case (op_r)
         3'b000: bit_s = a_r[0] | b_r[0];
         3'b001: bit_s = a_r[0] & b_r[0];
         3'b010: bit_s = ~a_r[0];
         3'b011: bit_s = ~(a_r[0] | b_r[0]);
         3'b100: bit_s = ~(a_r[0] & b_r[0]);
         3'b101: bit_s = a_r[0];
         3'b110,
         3'b111: begin
            bit_s     = a_r[0] ^ b_r[0] ^ carry_r;
            carry_nxt = (a_r[0] & b_r[0]) | (a_r[0] & carry_r) | (b_r[0] & carry_r);
         end
      endcase
   end

   always_comb begin
      s_ins            = '0;
      s_ins[WIDTH-1]   = bit_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nxt = BUSY;
         BUSY:    if (last_bit)      state_nxt = DONE;
         DONE:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         carry_r  <= 1'b0;
         result_r <= '0;
         cout_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_r    <= bus.op;
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  carry_r <= (bus.op == 3'b111) ? bus.cin : 1'b0;
                  cnt     <= '0;
               end
            end
            BUSY: begin
               a_r      <= a_r >> 1;
               b_r      <= b_r >> 1;
               result_r <= (result_r >> 1) | s_ins;
               carry_r  <= carry_nxt;
               cnt      <= cnt + 1'b1;
               if (last_bit) cout_r <= is_add ? carry_nxt : 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == DONE);
   assign bus.result    = result_r;
   assign bus.cout      = cout_r;
   assign busy          = (state == BUSY);

endmodule

// File: tb/tb_alu3_serial_unit.sv
// Self-checking bench for alu3_serial_unit against a word-level reference model.
module tb_alu3_serial_unit;
   localparam int unsigned W = 4;

   logic clk;
   logic rst_n;
   logic busy;
   int   checks;
   int   errors;

   alu3_serial_unit_if #(.WIDTH(W)) bus ();

   alu3_serial_unit #(.WIDTH(W), .CW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Word-level reference: logic ops on whole vectors, adds via integer sum.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, output logic [W-1:0] r, output logic co);
      logic [W:0] sum;
      co = 1'b0;
      case (op)
         3'd0: r = a | b;
         3'd1: r = a & b;
         3'd2: r = ~a;
         3'd3: r = ~(a | b);
         3'd4: r = ~(a & b);
         3'd5: r = a;
         default: begin
            sum = {1'b0, a} + {1'b0, b} + ((op == 3'd7) ? (W+1)'(cin) : '0);
            r   = sum[W-1:0];
            co  = sum[W];
         end
      endcase
   endfunction

   // Issues one request, then overwrites the inputs with a2/b2/random op so late changes are exercised.
   task automatic run_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] a2, input logic [W-1:0] b2,
                          output logic [W-1:0] res, output logic co, output int lat);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.op        = op;
      bus.a         = a;
      bus.b         = b;
      bus.cin       = cin;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.a         = a2;
      bus.b         = b2;
      bus.op        = 3'($urandom);
      bus.cin       = ~cin;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) begin
            lat = i;
            break;
         end
      end
      res = bus.result;
      co  = bus.cout;
      if (lat > 0 && bus.rsp_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", bus.cout); end
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b busy=%b exp 1/0", bus.req_ready, busy); end
   endtask

   task automatic test_full_add();
      logic [W-1:0] r;
      logic         co;
      int           lat;
      run_txn(3'b111, 4'b1011, 4'b0110, 1'b1, 4'($urandom), 4'($urandom), r, co, lat);
      checks++; if (lat !== W) begin errors++; $display("FAIL full_add_latency got %0d exp %0d", lat, W); end
      checks++; if (r !== 4'b0010) begin errors++; $display("FAIL full_add_result got %b exp 0010", r); end
      checks++; if (co !== 1'b1) begin errors++; $display("FAIL full_add_cout got %b exp 1", co); end
   endtask

   task automatic test_half_add();
      logic [W-1:0] r;
      logic         co;
      int           lat;
      run_txn(3'b110, 4'b1111, 4'b0001, 1'b1, 4'($urandom), 4'($urandom), r, co, lat);
      checks++; if (lat !== W) begin errors++; $display("FAIL half_add_latency got %0d exp %0d", lat, W); end
      checks++; if (r !== 4'b0000) begin errors++; $display("FAIL half_add_result got %b exp 0000", r); end
      checks++; if (co !== 1'b1) begin errors++; $display("FAIL half_add_cout got %b exp 1", co); end
   endtask

   task automatic test_logic_sweep();
      logic [W-1:0] exp_tab [6];
      logic [W-1:0] r;
      logic         co;
      int           lat;
      exp_tab = '{4'b1110, 4'b1000, 4'b0011, 4'b0001, 4'b0111, 4'b1100};
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_txn(3'(i), 4'b1100, 4'b1010, 1'($urandom), 4'($urandom), 4'($urandom), r, co, lat);
         checks++; if (r !== exp_tab[i]) begin errors++; $display("FAIL logic_op%0d_result got %b exp %b", i, r, exp_tab[i]); end
         checks++; if (co !== 1'b0) begin errors++; $display("FAIL logic_op%0d_cout got %b exp 0", i, co); end
         checks++; if (lat !== W) begin errors++; $display("FAIL logic_op%0d_latency got %0d exp %0d", i, lat, W); end
      end
   endtask

   task automatic test_backpressure();
      logic [2:0]   op1, op2;
      logic [W-1:0] a1, b1, a2, b2, e1, e2;
      logic         c1, c2, ec1, ec2;
      int           lat;
      op1 = 3'b111; a1 = 4'($urandom); b1 = 4'($urandom); c1 = 1'($urandom);
      op2 = 3'($urandom); a2 = 4'($urandom); b2 = 4'($urandom); c2 = 1'($urandom);
      model(op1, a1, b1, c1, e1, ec1);
      model(op2, a2, b2, c2, e2, ec2);
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.op = op1; bus.a = a1; bus.b = b1; bus.cin = c1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) begin lat = i; break; end
      end
      checks++; if (lat !== W) begin errors++; $display("FAIL bp_latency got %0d exp %0d", lat, W); end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.req_valid = 1'b1; bus.op = op2; bus.a = a2; bus.b = b2; bus.cin = c2;
         end
         checks++; if (bus.result !== e1 || bus.cout !== ec1) begin errors++; $display("FAIL bp_hold_result cyc%0d got %b/%b exp %b/%b", i, bus.result, bus.cout, e1, ec1); end
         checks++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_stall cyc%0d got ready=%b valid=%b exp 0/1", i, bus.req_ready, bus.rsp_valid); end
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release_idle got valid=%b ready=%b busy=%b exp 0/1/0", bus.rsp_valid, bus.req_ready, busy); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_queued_accept got busy=%b ready=%b exp 1/0", busy, bus.req_ready); end
      bus.req_valid = 1'b0;
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) begin lat = i; break; end
      end
      checks++; if (lat !== W) begin errors++; $display("FAIL bp_queued_latency got %0d exp %0d", lat, W); end
      checks++; if (bus.result !== e2 || bus.cout !== ec2) begin errors++; $display("FAIL bp_queued_result got %b/%b exp %b/%b", bus.result, bus.cout, e2, ec2); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_operand_change();
      logic [W-1:0] r;
      logic         co;
      int           lat;
      run_txn(3'b000, 4'b0001, 4'b0010, 1'b0, 4'b1111, 4'b0010, r, co, lat);
      checks++; if (r !== 4'b0011) begin errors++; $display("FAIL operand_change_result got %b exp 0011", r); end
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL operand_change_cout got %b exp 0", co); end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] r, e;
      logic         co, ec;
      int           lat;
      int           seen;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.op = 3'b111; bus.a = 4'b1011; bus.b = 4'b0110; bus.cin = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL async_reset_state got busy=%b ready=%b valid=%b exp 0/1/0", busy, bus.req_ready, bus.rsp_valid); end
      checks++; if (bus.result !== '0 || bus.cout !== 1'b0) begin errors++; $display("FAIL async_reset_outputs got %b/%b exp 0000/0", bus.result, bus.cout); end
      @(negedge clk);
      #2 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL async_reset_no_rsp got %0d active cycles exp 0", seen); end
      model(3'b111, 4'b0111, 4'b0101, 1'b0, e, ec);
      run_txn(3'b111, 4'b0111, 4'b0101, 1'b0, 4'($urandom), 4'($urandom), r, co, lat);
      checks++; if (lat !== W) begin errors++; $display("FAIL async_reset_next_latency got %0d exp %0d", lat, W); end
      checks++; if (r !== e || co !== ec) begin errors++; $display("FAIL async_reset_next_result got %b/%b exp %b/%b", r, co, e, ec); end
   endtask

   task automatic test_random();
      logic [2:0]   op;
      logic [W-1:0] a, b, r, e;
      logic         c, co, ec;
      int           lat;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 4'($urandom);
         b  = 4'($urandom);
         c  = 1'($urandom);
         model(op, a, b, c, e, ec);
         run_txn(op, a, b, c, 4'($urandom), 4'($urandom), r, co, lat);
         checks++; if (r !== e || co !== ec) begin errors++; $display("FAIL random%0d op=%0d a=%b b=%b cin=%b got %b/%b exp %b/%b", i, op, a, b, c, r, co, e, ec); end
         checks++; if (lat !== W) begin errors++; $display("FAIL random%0d_latency got %0d exp %0d", i, lat, W); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_full_add();
      test_half_add();
      test_logic_sweep();
      test_backpressure();
      test_operand_change();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
